cp0_register_file: RTL and testbench

Holds the coprocessor-0 state (SR, Cause, EPC, Count, Compare, PRId) and is the write target for the CP0 submission logic. It sits beside the writeback stage. It accepts per-register write strobes from the submitter and mtc0 writes for the timer registers. It feeds current_SR/current_Cause back to the submitter, serves combinational mfc0 reads, and synchronizes external interrupt lines into the 6-bit interrupt request vector.

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/irq_synchronizer.sv | 27 ++
 rtl/cp0_register_file.sv | 92 +++++++++
 tb/tb_cp0_register_file.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 register file and the
// submitter that writes it. Register addresses, architectural field positions
// and the writable-bit masks for SR, Cause and EPC.
package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  typedef enum logic [4:0] {
    CP0_COUNT   = 5'd9,
    CP0_COMPARE = 5'd11,
    CP0_SR      = 5'd12,
    CP0_CAUSE   = 5'd13,
    CP0_EPC     = 5'd14,
    CP0_PRID    = 5'd15
  } cp0_reg_e;

  // SR fields
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  // Cause fields
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LO   = 10;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;

  localparam int NUM_IRQ = CAUSE_IP_HI - CAUSE_IP_LO + 1;

  // Writable masks; bits outside are stored as 0
  localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [31:0] CAUSE_MASK = 32'h8000_FC7C;
  localparam logic [31:0] EPC_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/irq_synchronizer.sv
// irq_synchronizer: two-flop metastability guard, one chain per bit.
//   clk, rst_n : clock, async active-low reset (clears both stages)
//   din        : asynchronous level inputs
//   dout       : synchronized outputs, two edges behind din
module irq_synchronizer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [1:0][W-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      stage[1] <= stage[0];
    end
  end

  assign dout = stage[1];

endmodule

// File: rtl/cp0_register_file.sv
// cp0_register_file: coprocessor-0 state (SR, Cause, EPC, Count, Compare,
// PRId) beside the writeback stage.
//   clk, rst_n             : clock, async active-low reset
//   *_enable / new_*       : dedicated SR/Cause/EPC write strobes from the submitter
//   mtc0_*                 : generic write port, only Count (9) and Compare (11) act
//   hw_irq_raw             : asynchronous device interrupt levels
//   read_address/read_data : combinational mfc0 read (no write bypass)
//   current_SR/Cause/EPC   : register contents back to the submitter
//   interrupt_request      : synchronized IP vector, bit 15 also carries the timer
module cp0_register_file
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_5200,
  parameter logic [31:0] SR_RESET   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SR_enable,
  input  logic [31:0] new_SR,
  input  logic        Cause_enable,
  input  logic [31:0] new_Cause,
  input  logic        EPC_enable,
  input  logic [31:0] new_EPC,
  input  logic        mtc0_enable,
  input  logic [4:0]  mtc0_address,
  input  logic [31:0] mtc0_data,
  input  logic [5:0]  hw_irq_raw,
  input  logic [4:0]  read_address,
  output logic [31:0] read_data,
  output logic [31:0] current_SR,
  output logic [31:0] current_Cause,
  output logic [31:0] current_EPC,
  output logic [15:10] interrupt_request
);

  logic [31:0]        sr_q, cause_q, epc_q, count_q, compare_q;
  logic               timer_pending;
  logic [NUM_IRQ-1:0] irq_sync;
  logic               count_wr, compare_wr;
  logic [31:0]        count_next;

  irq_synchronizer #(.W(NUM_IRQ)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (hw_irq_raw),
    .dout  (irq_sync)
  );

  assign count_wr   = mtc0_enable && (mtc0_address == CP0_COUNT);
  assign compare_wr = mtc0_enable && (mtc0_address == CP0_COMPARE);
  // A Count write replaces that cycle's increment
  assign count_next = count_wr ? mtc0_data : count_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q          <= SR_RESET & SR_MASK;
      cause_q       <= '0;
      epc_q         <= '0;
      count_q       <= '0;
      compare_q     <= 32'hFFFF_FFFF;
      timer_pending <= 1'b0;
    end else begin
      if (SR_enable)    sr_q    <= new_SR    & SR_MASK;
      if (Cause_enable) cause_q <= new_Cause & CAUSE_MASK;
      if (EPC_enable)   epc_q   <= new_EPC   & EPC_MASK;
      count_q <= count_next;
      if (compare_wr) compare_q <= mtc0_data;
      // Compare write has priority over a match on the same edge
      if (compare_wr)                    timer_pending <= 1'b0;
      else if (count_next == compare_q)  timer_pending <= 1'b1;
    end
  end

  always_comb begin
    read_data = '0;
    case (read_address)
      CP0_COUNT:   read_data = count_q;
      CP0_COMPARE: read_data = compare_q;
      CP0_SR:      read_data = sr_q;
      CP0_CAUSE:   read_data = cause_q;
      CP0_EPC:     read_data = epc_q;
      CP0_PRID:    read_data = PRID_VALUE;
      default:     read_data = '0;
    endcase
  end

  assign current_SR        = sr_q;
  assign current_Cause     = cause_q;
  assign current_EPC       = epc_q;
  assign interrupt_request = {irq_sync[5] | timer_pending, irq_sync[4:0]};

endmodule

// File: tb/tb_cp0_register_file.sv
module tb_cp0_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SR_enable, Cause_enable, EPC_enable, mtc0_enable;
  logic [31:0] new_SR, new_Cause, new_EPC, mtc0_data;
  logic [4:0]  mtc0_address, read_address;
  logic [5:0]  hw_irq_raw;
  logic [31:0] read_data, current_SR, current_Cause, current_EPC;
  logic [15:10] interrupt_request;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  cp0_register_file dut (
    .clk(clk), .rst_n(rst_n),
    .SR_enable(SR_enable), .new_SR(new_SR),
    .Cause_enable(Cause_enable), .new_Cause(new_Cause),
    .EPC_enable(EPC_enable), .new_EPC(new_EPC),
    .mtc0_enable(mtc0_enable), .mtc0_address(mtc0_address), .mtc0_data(mtc0_data),
    .hw_irq_raw(hw_irq_raw), .read_address(read_address), .read_data(read_data),
    .current_SR(current_SR), .current_Cause(current_Cause), .current_EPC(current_EPC),
    .interrupt_request(interrupt_request)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear();
    SR_enable = 0; Cause_enable = 0; EPC_enable = 0; mtc0_enable = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_enable = 1; mtc0_address = a; mtc0_data = d;
  endtask

  function automatic logic [31:0] ir15();
    return {31'd0, interrupt_request[15]};
  endfunction

  initial begin
    rst_n = 0; clear();
    new_SR = 0; new_Cause = 0; new_EPC = 0; mtc0_address = 0; mtc0_data = 0;
    hw_irq_raw = 0; read_address = 5'd9;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Count starts on first edge after release
    push(32'd1); step(); check("count_first_edge", read_data);

    // Masking
    SR_enable = 1; new_SR = 32'hFFFF_FFFF; read_address = 5'd12;
    push(32'h0000_FC03); push(32'h0000_FC03);
    step(); clear(); check("sr_mask", current_SR); check("sr_read", read_data);
    Cause_enable = 1; new_Cause = 32'hFFFF_FFFF;
    push(32'h8000_FC7C); step(); clear(); check("cause_mask", current_Cause);
    EPC_enable = 1; new_EPC = 32'h0000_3007;
    push(32'h0000_3004); step(); clear(); check("epc_mask", current_EPC);

    // Same-cycle strobes; read in strobe cycle returns old EPC
    SR_enable = 1; new_SR = 32'h0000_0401;
    Cause_enable = 1; new_Cause = 32'h0000_0404;
    EPC_enable = 1; new_EPC = 32'h1234_5679;
    read_address = 5'd14;
    #1 push(32'h0000_3004); check("epc_no_bypass", read_data);
    push(32'h0000_0401); push(32'h0000_0404); push(32'h1234_5678);
    step(); clear();
    check("multi_sr", current_SR); check("multi_cause", current_Cause); check("multi_epc", current_EPC);

    // Asynchronous reset mid-cycle
    #2 rst_n = 0;
    #1;
    push(0); check("rst_sr", current_SR);
    push(0); check("rst_cause", current_Cause);
    push(0); check("rst_epc", current_EPC);
    push(0); check("rst_irq", {26'd0, interrupt_request});
    read_address = 5'd15; #1 push(32'h0000_5200); check("rst_prid", read_data);
    read_address = 5'd11; #1 push(32'hFFFF_FFFF); check("rst_compare", read_data);
    read_address = 5'd9;  #1 push(0); check("rst_count", read_data);
    // Write during reset is lost, Count held
    SR_enable = 1; new_SR = 32'hFFFF_FFFF;
    push(0); push(0);
    step(); check("rst_write_lost", current_SR); check("rst_count_held", read_data);
    clear(); rst_n = 1;
    push(32'd1); step(); check("count_after_rerelease", read_data);

    // Synchronizer: 2 edges in, 2 edges out
    hw_irq_raw = 6'b000100;
    push(0); step(); check("sync_rise_e1", {31'd0, interrupt_request[12]});
    push(32'h4); step(); check("sync_rise_e2", {26'd0, interrupt_request});
    hw_irq_raw = 0;
    push(1); step(); check("sync_fall_e1", {31'd0, interrupt_request[12]});
    push(0); step(); check("sync_fall_e2", {31'd0, interrupt_request[12]});

    // Timer: Compare=20, Count=10
    mtc0(5'd11, 32'd20); read_address = 5'd11;
    push(32'd20); step(); clear(); check("compare_wr", read_data);
    mtc0(5'd9, 32'd10); read_address = 5'd9;
    push(32'd10); step(); clear(); check("count_wr", read_data);
    repeat (9) step();
    push(32'd19); push(0); check("count_19", read_data); check("timer_before", ir15());
    push(32'd20); push(1); step(); check("count_20", read_data); check("timer_set", ir15());
    push(1); step(); step(); check("timer_held", ir15());
    mtc0(5'd11, 32'd100); read_address = 5'd11;
    push(0); push(32'd100); step(); clear();
    check("timer_cleared", ir15()); check("compare_100", read_data);

    // Compare write in match cycle: write wins
    mtc0(5'd9, 32'd99); read_address = 5'd9;
    push(32'd99); step(); clear(); check("count_99", read_data);
    mtc0(5'd11, 32'd200);
    push(0); push(32'd100); step(); clear();
    check("match_cycle_cmp_wr", ir15()); check("count_100", read_data);
    read_address = 5'd11; #1 push(32'd200); check("compare_200", read_data);

    // Wrap and override
    mtc0(5'd9, 32'hFFFF_FFFF); read_address = 5'd9;
    push(32'hFFFF_FFFF); step(); clear(); check("count_max", read_data);
    push(0); step(); check("count_wrap", read_data);
    mtc0(5'd9, 32'h0000_1234);
    push(32'h0000_1234); step(); clear(); check("count_override", read_data);

    // Generic port ignored for SR/Cause/EPC; unmapped address reads 0
    mtc0(5'd12, 32'hFFFF_FFFF); step();
    mtc0(5'd13, 32'hFFFF_FFFF); step();
    mtc0(5'd14, 32'hFFFF_FFFF); step(); clear();
    push(0); check("mtc0_sr_ign", current_SR);
    push(0); check("mtc0_cause_ign", current_Cause);
    push(0); check("mtc0_epc_ign", current_EPC);
    read_address = 5'd3; #1 push(0); check("unmapped_read", read_data);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d expected values left unchecked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
